// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one byte at a time from the FIFO read port and sends it as a UART 8N1 frame.
// A frame starts only from IDLE, so the FIFO is never read while it reports empty.
module fifo_uart_tx #(
    parameter int CLK_DIV = 868,
    parameter int DATA_W  = 8,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               clear_n,
    input  logic               enable,
    input  logic               fifo_empty,
    input  logic [DATA_W-1:0]  fifo_dout,
    output logic               fifo_rd_en,
    output logic               tx,
    output logic               busy,
    output logic               tx_done,
    output logic [COUNT_W-1:0] byte_count,
    output logic [2:0]         dbg_state
);

    localparam int BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LATCH = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } state_t;

    state_t              state;
    logic [BAUD_W-1:0]   baud_cnt;
    logic [IDX_W-1:0]    bit_idx;
    logic [DATA_W-1:0]   shift;
    logic                baud_last;
    logic [IDX_W-1:0]    next_idx;

    assign baud_last = (baud_cnt == BAUD_LAST);
    assign next_idx  = bit_idx + IDX_W'(1);
    assign dbg_state = state;

    // Read handshake: fifo_rd_en is a one-cycle pulse raised from IDLE; the FIFO pops on the
    // following edge and fifo_dout is captured one edge after that, in LATCH.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state      <= IDLE;
            fifo_rd_en <= 1'b0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
            byte_count <= '0;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift      <= '0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable && !fifo_empty) begin
                        fifo_rd_en <= 1'b1;
                        busy       <= 1'b1;
                        state      <= FETCH;
                    end
                end
                FETCH: begin
                    fifo_rd_en <= 1'b0;
                    state      <= LATCH;
                end
                LATCH: begin
                    shift    <= fifo_dout;
                    tx       <= 1'b0;
                    baud_cnt <= '0;
                    state    <= START;
                end
                START: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        tx       <= shift[0];
                        bit_idx  <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                DATA: begin
                    // LSB first; the stop level goes out straight after the last data bit.
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (bit_idx == IDX_LAST) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= next_idx;
                            tx      <= shift[next_idx];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (baud_last) begin
                        baud_cnt   <= '0;
                        tx_done    <= 1'b1;
                        byte_count <= byte_count + COUNT_W'(1);
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                default: begin
                    fifo_rd_en <= 1'b0;
                    tx         <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a queue-backed FIFO model feeds the DUT, and a line-level UART receiver
// decodes tx. Expected bytes, frame timing and byte counts come from the frame rules.
module tb_fifo_uart_tx;

    localparam int CLK_DIV = 4;
    localparam int DATA_W  = 8;
    localparam int COUNT_W = 4;
    localparam int FRAME   = 10 * CLK_DIV;
    localparam int PERIOD  = FRAME + 3;

    logic               clk = 1'b0;
    logic               clear_n;
    logic               enable;
    logic               fifo_empty;
    logic [DATA_W-1:0]  fifo_dout = '0;
    logic               fifo_rd_en;
    logic               tx;
    logic               busy;
    logic               tx_done;
    logic [COUNT_W-1:0] byte_count;
    logic [2:0]         dbg_state;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    fifo_uart_tx #(.CLK_DIV(CLK_DIV), .DATA_W(DATA_W), .COUNT_W(COUNT_W)) dut (
        .clk        (clk),
        .clear_n    (clear_n),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .tx         (tx),
        .busy       (busy),
        .tx_done    (tx_done),
        .byte_count (byte_count),
        .dbg_state  (dbg_state)
    );

    // FIFO model: data appears on fifo_dout on the edge that samples fifo_rd_en.
    logic [DATA_W-1:0] mem [0:255];
    int   push_ptr  = 0;
    int   pop_ptr   = 0;
    logic underflow = 1'b0;
    assign fifo_empty = (push_ptr == pop_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en === 1'b1) begin
            if (push_ptr == pop_ptr) underflow <= 1'b1;
            else begin
                fifo_dout <= mem[pop_ptr % 256];
                pop_ptr   <= pop_ptr + 1;
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   rd_pulses   = 0;
    int   done_pulses = 0;
    int   rd_wide     = 0;
    int   rd_times[$];
    logic prev_rd     = 1'b0;
    always @(negedge clk) begin
        if (fifo_rd_en === 1'b1) begin
            rd_pulses++;
            rd_times.push_back(cyc);
            if (prev_rd) rd_wide++;
        end
        if (tx_done === 1'b1) done_pulses++;
        prev_rd = fifo_rd_en;
    end

    logic [DATA_W-1:0] exp_q[$];
    int exp_frames = 0;

    task automatic push_byte(input logic [DATA_W-1:0] b);
        mem[push_ptr % 256] = b;
        push_ptr = push_ptr + 1;
        exp_q.push_back(b);
    endtask

    // Line receiver: waits for a start bit, then samples each bit mid-cell.
    // Returns on the last cycle of the stop bit.
    task automatic rx_frame(output logic [DATA_W-1:0] data, output logic ok);
        logic       found;
        logic [9:0] bits;
        found = 1'b0;
        bits  = '0;
        data  = '0;
        ok    = 1'b0;
        for (int t = 0; t < 60 && !found; t++) begin
            @(negedge clk);
            if (tx === 1'b0) found = 1'b1;
        end
        if (found) begin
            for (int i = 0; i < FRAME; i++) begin
                if (i > 0) @(negedge clk);
                if (i % CLK_DIV == CLK_DIV / 2) bits[i / CLK_DIV] = tx;
            end
            data = bits[8:1];
            ok   = (bits[0] === 1'b0) && (bits[9] === 1'b1);
        end
    endtask

    task automatic test_reset();
        logic found;
        logic [DATA_W-1:0] lost;
        clear_n = 1'b0;
        enable  = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (tx !== 1'b1 || fifo_rd_en !== 1'b0 || busy !== 1'b0 || tx_done !== 1'b0 || byte_count !== '0) begin
            errors++;
            $display("FAIL reset_values got tx=%b rd_en=%b busy=%b done=%b count=%0d want 1 0 0 0 0",
                     tx, fifo_rd_en, busy, tx_done, byte_count);
        end
        @(negedge clk);
        clear_n = 1'b1;
        exp_frames = 0;
        push_byte(8'($urandom_range(0, 255)));
        enable = 1'b1;
        found = 1'b0;
        for (int t = 0; t < 20 && !found; t++) begin
            @(negedge clk);
            if (tx === 1'b0) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reset_frame_start got tx=%b want start bit 0 within 20 clks", tx);
        end
        repeat (2) @(negedge clk);
        #3 clear_n = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL reset_async_tx got %b want 1", tx);
        end
        checks++;
        if (fifo_rd_en !== 1'b0 || busy !== 1'b0 || byte_count !== '0) begin
            errors++;
            $display("FAIL reset_async_flags got rd_en=%b busy=%b count=%0d want 0 0 0", fifo_rd_en, busy, byte_count);
        end
        lost = exp_q.pop_front();
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        clear_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_idle got busy=%b tx=%b want 0 1 (byte %h lost)", busy, tx, lost);
        end
    endtask

    task automatic test_single_byte();
        logic [9:0]       frame;
        logic [FRAME-1:0] expw;
        logic [FRAME-1:0] got;
        logic [DATA_W-1:0] b;
        logic found, busy_end;
        int rd0, done0, lat;
        push_byte(8'hA5);
        b = exp_q.pop_front();
        frame = {1'b1, b, 1'b0};
        for (int i = 0; i < FRAME; i++) expw[i] = frame[i / CLK_DIV];
        rd0 = rd_pulses;
        done0 = done_pulses;
        enable = 1'b1;
        found = 1'b0;
        for (int t = 0; t < 20 && !found; t++) begin
            @(negedge clk);
            if (tx === 1'b0) found = 1'b1;
        end
        lat = (rd_times.size() > 0) ? cyc - rd_times[$] : -1;
        checks++;
        if (!found || lat != 2) begin
            errors++;
            $display("FAIL single_latency got found=%b rd_to_start=%0d want 1 2", found, lat);
        end
        got[0] = tx;
        for (int i = 1; i < FRAME; i++) begin
            @(negedge clk);
            got[i] = tx;
        end
        busy_end = busy;
        checks++;
        if (got !== expw) begin
            errors++;
            $display("FAIL single_wave got %h want %h", got, expw);
        end
        checks++;
        if (busy_end !== 1'b1) begin
            errors++;
            $display("FAIL single_busy_in_stop got %b want 1", busy_end);
        end
        @(negedge clk);
        checks++;
        if (tx_done !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) begin
            errors++;
            $display("FAIL single_end got done=%b busy=%b tx=%b want 1 0 1", tx_done, busy, tx);
        end
        @(negedge clk);
        exp_frames++;
        checks++;
        if (tx_done !== 1'b0 || byte_count !== COUNT_W'(exp_frames % (1 << COUNT_W))) begin
            errors++;
            $display("FAIL single_count got done=%b count=%0d want 0 %0d", tx_done, byte_count, exp_frames);
        end
        checks++;
        if (rd_pulses - rd0 != 1 || done_pulses - done0 != 1) begin
            errors++;
            $display("FAIL single_pulses got rd=%0d done=%0d want 1 1", rd_pulses - rd0, done_pulses - done0);
        end
    endtask

    task automatic test_burst();
        logic [DATA_W-1:0] d, e;
        logic ok;
        int rd0, bad;
        @(negedge clk) clear_n = 1'b0;
        @(negedge clk) clear_n = 1'b1;
        exp_frames = 0;
        checks++;
        if (byte_count !== '0) begin
            errors++;
            $display("FAIL burst_count_start got %0d want 0", byte_count);
        end
        rd0 = rd_times.size();
        for (int k = 0; k < 16; k++) push_byte(8'(k * 8));
        for (int k = 0; k < 16; k++) begin
            rx_frame(d, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || d !== e) begin
                errors++;
                $display("FAIL burst_data[%0d] got %h framing_ok=%b want %h 1", k, d, ok, e);
            end
            @(negedge clk);
            exp_frames++;
            checks++;
            if (tx_done !== 1'b1 || byte_count !== COUNT_W'(exp_frames % (1 << COUNT_W))) begin
                errors++;
                $display("FAIL burst_count[%0d] got done=%b count=%0d want 1 %0d", k, tx_done, byte_count,
                         exp_frames % (1 << COUNT_W));
            end
        end
        bad = 0;
        if (rd_times.size() - rd0 != 16) bad = 100;
        else for (int i = 1; i < 16; i++) if (rd_times[rd0 + i] - rd_times[rd0 + i - 1] != PERIOD) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL burst_period got %0d pops, %0d bad gaps want 16 pops every %0d clks",
                     rd_times.size() - rd0, bad, PERIOD);
        end
        checks++;
        if (underflow !== 1'b0 || byte_count !== '0) begin
            errors++;
            $display("FAIL burst_wrap got underflow=%b count=%0d want 0 0", underflow, byte_count);
        end
    endtask

    task automatic test_enable_gating();
        logic [DATA_W-1:0] d, e;
        logic ok, busy_seen;
        int rd0;
        @(negedge clk);
        enable = 1'b0;
        for (int k = 0; k < 3; k++) push_byte(8'($urandom_range(0, 255)));
        rd0 = rd_pulses;
        repeat (100) @(negedge clk);
        checks++;
        if (rd_pulses != rd0 || busy !== 1'b0 || tx !== 1'b1) begin
            errors++;
            $display("FAIL gate_hold got pops=%0d busy=%b tx=%b want 0 0 1", rd_pulses - rd0, busy, tx);
        end
        enable = 1'b1;
        busy_seen = 1'b0;
        fork
            rx_frame(d, ok);
            begin
                for (int t = 0; t < 20 && !busy_seen; t++) begin
                    @(negedge clk);
                    if (busy === 1'b1) busy_seen = 1'b1;
                end
                repeat (12) @(negedge clk);
                enable = 1'b0;
            end
        join
        e = exp_q.pop_front();
        exp_frames++;
        checks++;
        if (!busy_seen || !ok || d !== e) begin
            errors++;
            $display("FAIL gate_frame got busy_seen=%b data=%h ok=%b want 1 %h 1", busy_seen, d, ok, e);
        end
        repeat (100) @(negedge clk);
        checks++;
        if (rd_pulses - rd0 != 1 || busy !== 1'b0 || tx !== 1'b1 ||
            byte_count !== COUNT_W'(exp_frames % (1 << COUNT_W))) begin
            errors++;
            $display("FAIL gate_after got pops=%0d busy=%b tx=%b count=%0d want 1 0 1 %0d",
                     rd_pulses - rd0, busy, tx, byte_count, exp_frames % (1 << COUNT_W));
        end
    endtask

    task automatic test_reset_mid_data();
        logic [DATA_W-1:0] d, e, lost;
        logic ok, busy_seen, held;
        push_byte(8'($urandom_range(0, 255)));
        enable = 1'b1;
        busy_seen = 1'b0;
        for (int t = 0; t < 20 && !busy_seen; t++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_seen = 1'b1;
        end
        repeat (12) @(negedge clk);
        #3 clear_n = 1'b0;
        #1;
        checks++;
        if (!busy_seen || tx !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0 || byte_count !== '0) begin
            errors++;
            $display("FAIL middata_reset got seen=%b tx=%b busy=%b rd_en=%b count=%0d want 1 1 0 0 0",
                     busy_seen, tx, busy, fifo_rd_en, byte_count);
        end
        held = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) held = 1'b0;
        end
        checks++;
        if (!held) begin
            errors++;
            $display("FAIL middata_held got tx=%b busy=%b want 1 0 throughout reset", tx, busy);
        end
        lost = exp_q.pop_front();
        exp_frames = 0;
        clear_n = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            rx_frame(d, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || d !== e) begin
                errors++;
                $display("FAIL middata_next[%0d] got %h ok=%b want %h 1 (lost %h)", k, d, ok, e, lost);
            end
            @(negedge clk);
            exp_frames++;
            checks++;
            if (tx_done !== 1'b1 || byte_count !== COUNT_W'(exp_frames)) begin
                errors++;
                $display("FAIL middata_count[%0d] got done=%b count=%0d want 1 %0d", k, tx_done, byte_count, exp_frames);
            end
        end
    endtask

    task automatic test_empty_boundary();
        logic [DATA_W-1:0] d, e;
        logic ok, quiet;
        int rd0;
        enable = 1'b1;
        rd0 = rd_pulses;
        push_byte(8'($urandom_range(0, 255)));
        rx_frame(d, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || d !== e) begin
            errors++;
            $display("FAIL empty_data got %h ok=%b want %h 1", d, ok, e);
        end
        @(negedge clk);
        exp_frames++;
        checks++;
        if (busy !== 1'b0 || tx_done !== 1'b1 || tx !== 1'b1 ||
            byte_count !== COUNT_W'(exp_frames % (1 << COUNT_W))) begin
            errors++;
            $display("FAIL empty_end got busy=%b done=%b tx=%b count=%0d want 0 1 1 %0d",
                     busy, tx_done, tx, byte_count, exp_frames % (1 << COUNT_W));
        end
        quiet = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet || rd_pulses - rd0 != 1) begin
            errors++;
            $display("FAIL empty_quiet got quiet=%b pops=%0d want 1 1", quiet, rd_pulses - rd0);
        end
        checks++;
        if (underflow !== 1'b0 || rd_wide != 0) begin
            errors++;
            $display("FAIL empty_strobe got underflow=%b wide_pulses=%0d want 0 0", underflow, rd_wide);
        end
    endtask

    initial begin
        clear_n = 1'b0;
        enable  = 1'b0;
        test_reset();
        test_single_byte();
        test_burst();
        test_enable_gating();
        test_reset_mid_data();
        test_empty_boundary();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog got no end of test want finish before 1 ms");
        $fatal(1, "watchdog");
    end

endmodule
